// File: rtl/virq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : virq_arbiter_if
// Summary  : Request/vector/ack bundle between the peripherals, the CPU and
//            virq_arbiter. The arbiter uses the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface virq_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         enable;
    logic [9*NREQ-1:0]       vectors;
    logic [NREQ-1:0]         ack;
    logic                    virq;
    logic [8:0]              virq_vector;
    logic                    virq_iack;
    logic [$clog2(NREQ)-1:0] active_id;

    modport master (
        output req, enable, vectors, virq_iack,
        input  ack, virq, virq_vector, active_id
    );

    modport slave (
        input  req, enable, vectors, virq_iack,
        output ack, virq, virq_vector, active_id
    );
endinterface
`default_nettype wire

// File: rtl/virq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : virq_arbiter
// Summary  : Fixed-priority vectored-interrupt arbiter (index 0 highest) with
//            level/edge ack handshake. VIRQ_TIMEOUT_EN adds an ACK hold limit.
// Revision : 1.0 - initial release
// ============================================================================
module virq_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    virq_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("virq_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_iack_prev;
    logic            r_virq;
    logic [NREQ-1:0] r_ack;
    logic [8:0]      r_vector;
    logic [ID_W-1:0] r_active_id;

    logic [NREQ-1:0] w_pend;
    logic            w_have_pend;
    logic [ID_W-1:0] w_winner;
    logic [8:0]      w_win_vec;
    logic            w_iack_edge;
    logic            w_req_active;
    logic            w_timeout;
    logic [ID_W-1:0] w_id_next;
    logic [8:0]      w_vec_next;
    logic [NREQ-1:0] w_ack_next;

    assign w_pend       = bus.req & bus.enable;
    assign w_have_pend  = |w_pend;
    assign w_iack_edge  = bus.virq_iack & ~r_iack_prev;
    assign w_req_active = bus.req[r_active_id];

    // Scan from the top so the lowest pending index is the last one written.
    always_comb begin
        w_winner  = '0;
        w_win_vec = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_winner  = ID_W'(i);
                w_win_vec = bus.vectors[9*i +: 9];
            end
        end
    end

`ifdef VIRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

    // Held at zero outside ACK, so every ACK entry starts a fresh count.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state != ACK) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_have_pend) w_state_next = OFFER;
            // An iack edge beats a same-cycle withdrawal: the CPU already took the vector.
            OFFER: begin
                if (w_iack_edge)       w_state_next = ACK;
                else if (!w_req_active) w_state_next = IDLE;
            end
            ACK:     if (!w_req_active || w_timeout) w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_id_next  = '0;
        w_vec_next = '0;
        w_ack_next = '0;
        case (w_state_next)
            OFFER: begin
                w_id_next  = (r_state == IDLE) ? w_winner  : r_active_id;
                w_vec_next = (r_state == IDLE) ? w_win_vec : r_vector;
            end
            ACK: begin
                w_id_next              = r_active_id;
                w_ack_next[r_active_id] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_iack_prev <= 1'b1;
            r_virq      <= 1'b0;
            r_ack       <= '0;
            r_vector    <= '0;
            r_active_id <= '0;
        end else begin
            r_state     <= w_state_next;
            r_iack_prev <= bus.virq_iack;
            r_virq      <= (w_state_next == OFFER);
            r_ack       <= w_ack_next;
            r_vector    <= w_vec_next;
            r_active_id <= w_id_next;
        end
    end

    assign bus.virq        = r_virq;
    assign bus.ack         = r_ack;
    assign bus.virq_vector = r_vector;
    assign bus.active_id   = r_active_id;

endmodule
`default_nettype wire
